// File: rtl/fir_accumulator_if.sv
// Sample bus between the FIR controller, the accumulator and the downstream consumer.
// Latency: none (wires only).
// Backpressure: SubStall is a credit-exhausted hold-off; the output side is valid/ready.
//
// Ports (signals):
//   SubValid, sub_prod_0..4 : controller -> accumulator. Each sub_prod_k is {I, Q},
//                             with I in the upper IN_W bits and Q in the lower IN_W bits.
//   SubStall                : accumulator -> controller.
//   OutValid, OutI, OutQ    : accumulator -> consumer.
//   OutReady                : consumer -> accumulator.
interface fir_accumulator_if #(
  parameter int IN_W  = 51,
  parameter int OUT_W = 24
);
  logic              SubValid;
  logic              SubStall;
  logic [2*IN_W-1:0] sub_prod_0;
  logic [2*IN_W-1:0] sub_prod_1;
  logic [2*IN_W-1:0] sub_prod_2;
  logic [2*IN_W-1:0] sub_prod_3;
  logic [2*IN_W-1:0] sub_prod_4;
  logic              OutValid;
  logic              OutReady;
  logic [OUT_W-1:0]  OutI;
  logic [OUT_W-1:0]  OutQ;

  // Controller and consumer side
  modport master (
    output SubValid, sub_prod_0, sub_prod_1, sub_prod_2, sub_prod_3, sub_prod_4, OutReady,
    input  SubStall, OutValid, OutI, OutQ
  );

  // Accumulator side
  modport slave (
    input  SubValid, sub_prod_0, sub_prod_1, sub_prod_2, sub_prod_3, sub_prod_4, OutReady,
    output SubStall, OutValid, OutI, OutQ
  );
endinterface

// File: rtl/fir_accumulator.sv
// Sums five I/Q partial products (4.47), then rounds half-up and saturates them to 1.23 samples.
// Latency: an input accepted in cycle N is written to the FIFO at the end of N+2,
//          so OutValid rises in N+3 when the FIFO starts out empty.
// Backpressure: credit based. SubStall rises when FIFO entries plus in-flight samples reach DEPTH.
//
// Ports:
//   Clk, Reset : single rising-edge clock; synchronous active-high reset.
//   bus        : fir_accumulator_if slave (sub-product input, SubStall, FIFO output handshake).
//   OvfErr     : sticky flag, set when SubValid arrives while SubStall is high.
//   SatCnt     : saturating count of clipped output components.
module fir_accumulator #(
  parameter int IN_W     = 51,
  parameter int IN_FRAC  = 47,
  parameter int OUT_W    = 24,
  parameter int OUT_FRAC = 23,
  parameter int DEPTH    = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  fir_accumulator_if.slave     bus,
  output logic                 OvfErr,
  output logic [15:0]          SatCnt
);

  localparam int SW = IN_W + 1;            // width of an S1 pair sum
  localparam int TW = IN_W + 3;            // width of the S2 five-term sum
  localparam int SH = IN_FRAC - OUT_FRAC;  // fractional bits removed by rounding
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;              // fifo_count must be able to hold DEPTH

  // Rounding and clipping constants, sized to the widened rounding sum
  localparam logic signed [TW:0] HALF = {{(TW+1-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic signed [TW:0] OMAX = {{(TW+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [TW:0] OMIN = {{(TW+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  // Channel 0 is I, channel 1 is Q
  logic signed [IN_W-1:0] p [2][5];

  always_comb begin
    p[0][0] = bus.sub_prod_0[2*IN_W-1:IN_W];  p[1][0] = bus.sub_prod_0[IN_W-1:0];
    p[0][1] = bus.sub_prod_1[2*IN_W-1:IN_W];  p[1][1] = bus.sub_prod_1[IN_W-1:0];
    p[0][2] = bus.sub_prod_2[2*IN_W-1:IN_W];  p[1][2] = bus.sub_prod_2[IN_W-1:0];
    p[0][3] = bus.sub_prod_3[2*IN_W-1:IN_W];  p[1][3] = bus.sub_prod_3[IN_W-1:0];
    p[0][4] = bus.sub_prod_4[2*IN_W-1:IN_W];  p[1][4] = bus.sub_prod_4[IN_W-1:0];
  end

  // ---------------- datapath (no reset needed: qualified by the valid pipe) ----------------
  logic signed [SW-1:0]   a_d [2], a_q [2], b_d [2], b_q [2];
  logic signed [IN_W-1:0] p4_d[2], p4_q[2];
  logic signed [TW-1:0]   t_d [2], t_q [2];
  logic signed [TW:0]     rnd [2], r [2];
  logic                   sat_hi[2], sat_lo[2];
  logic [OUT_W-1:0]       res [2];

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      a_d[ch]  = SW'(p[ch][0]) + SW'(p[ch][1]);
      b_d[ch]  = SW'(p[ch][2]) + SW'(p[ch][3]);
      p4_d[ch] = p[ch][4];
      t_d[ch]  = TW'(a_q[ch]) + TW'(b_q[ch]) + TW'(p4_q[ch]);
      // One extra bit so adding the half-LSB can never wrap
      rnd[ch]    = {t_q[ch][TW-1], t_q[ch]} + HALF;
      r[ch]      = rnd[ch] >>> SH;
      sat_hi[ch] = (r[ch] > OMAX);
      sat_lo[ch] = (r[ch] < OMIN);
      if (sat_hi[ch])      res[ch] = OMAX[OUT_W-1:0];
      else if (sat_lo[ch]) res[ch] = OMIN[OUT_W-1:0];
      else                 res[ch] = r[ch][OUT_W-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      a_q[ch]  <= a_d[ch];
      b_q[ch]  <= b_d[ch];
      p4_q[ch] <= p4_d[ch];
      t_q[ch]  <= t_d[ch];
    end
  end

  // ---------------- control: valid pipe, credits, FIFO pointers, status ----------------
  logic             v1_d, v1_q, v2_d, v2_q;
  logic [PW-1:0]    wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [CW-1:0]    fifo_count_d, fifo_count_q;
  logic             ovf_err_d, ovf_err_q;
  logic [15:0]      sat_cnt_d, sat_cnt_q;
  logic [CW:0]      used;
  logic             sub_stall, sub_acc, out_valid, push, pop;
  logic [1:0]       sat_inc;
  logic [16:0]      sat_sum;

  always_comb begin
    // Credits are zero once FIFO entries plus in-flight samples reach DEPTH
    used      = {1'b0, fifo_count_q} + {{CW{1'b0}}, v1_q} + {{CW{1'b0}}, v2_q};
    sub_stall = (used == (CW+1)'(DEPTH));
    sub_acc   = bus.SubValid & ~sub_stall;
    out_valid = (fifo_count_q != '0);
    push      = v2_q;  // S3 is combinational, so the third pipe stage is the FIFO write itself
    pop       = out_valid & bus.OutReady;

    v1_d = sub_acc;
    v2_d = v1_q;

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    fifo_count_d = fifo_count_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    ovf_err_d = ovf_err_q | (bus.SubValid & sub_stall);

    sat_inc   = {1'b0, sat_hi[0] | sat_lo[0]} + {1'b0, sat_hi[1] | sat_lo[1]};
    sat_sum   = {1'b0, sat_cnt_q} + {15'd0, sat_inc};
    sat_cnt_d = sat_cnt_q;
    if (push) sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      ovf_err_q    <= 1'b0;
      sat_cnt_q    <= '0;
    end else begin
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      ovf_err_q    <= ovf_err_d;
      sat_cnt_q    <= sat_cnt_d;
    end
  end

  // FIFO storage; entries are only meaningful between rd_ptr and wr_ptr
  logic [2*OUT_W-1:0] mem_q [DEPTH];
  logic [2*OUT_W-1:0] head;

  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_ptr_q] <= {res[0], res[1]};
  end

  assign head         = mem_q[rd_ptr_q];
  assign bus.SubStall = sub_stall;
  assign bus.OutValid = out_valid;
  assign bus.OutI     = out_valid ? head[2*OUT_W-1:OUT_W] : '0;
  assign bus.OutQ     = out_valid ? head[OUT_W-1:0]       : '0;
  assign OvfErr       = ovf_err_q;
  assign SatCnt       = sat_cnt_q;

endmodule
